// File: rtl/axi_sram_pkg.sv
// Shared encodings for the burst-capable AXI4 SRAM model: burst/resp codes,
// channel FSM states and the worst-response merge used for bresp.
package axi_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DATA, W_RESP} wr_state_e;

  // DECERR dominates SLVERR, which dominates OKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address stepping (FIXED/INCR/WRAP) plus detection of burst
// parameters the memory cannot honour.
module axi_burst_addr_gen
  import axi_sram_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [2:0]          size,
  input  logic [7:0]          len,
  input  logic [1:0]          burst,
  output logic [ADDR_LEN-1:0] next_addr,
  output logic                illegal
);

  localparam int MAX_SIZE = $clog2(DATA_LEN / 8);

  logic [ADDR_LEN-1:0] step;
  logic [ADDR_LEN-1:0] span_mask;
  logic [ADDR_LEN-1:0] incr_addr;
  logic                wrap_len_ok;

  always_comb begin
    step        = ADDR_LEN'(1) << size;
    // Wrap span is a power of two whenever the wrap length is legal.
    span_mask   = (step * (ADDR_LEN'(len) + ADDR_LEN'(1))) - ADDR_LEN'(1);
    incr_addr   = addr + step;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    illegal     = (int'(size) > MAX_SIZE) || (burst == BURST_RSVD) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~span_mask) | (incr_addr & span_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_burst.sv
// AXI4 slave memory model with ID echo, FIXED/INCR/WRAP bursts, byte strobes,
// address decode errors and configurable latency; read and write run independently.
module axi_sram_burst
  import axi_sram_pkg::*;
#(
  parameter int                    ADDR_LEN  = 32,
  parameter int                    DATA_LEN  = 32,
  parameter int                    ID_LEN    = 4,
  parameter int                    MEM_WORDS = 4096,
  parameter logic [ADDR_LEN-1:0]   BASE_ADDR = 32'h8000_0000,
  parameter int                    RD_LAT    = 2,
  parameter int                    WR_LAT    = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_LEN-1:0]   araddr,
  input  logic [ID_LEN-1:0]     arid,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_LEN-1:0]   rdata,
  output logic [1:0]            rresp,
  output logic [ID_LEN-1:0]     rid,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_LEN-1:0]   awaddr,
  input  logic [ID_LEN-1:0]     awid,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_LEN-1:0]   wdata,
  input  logic [DATA_LEN/8-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic [ID_LEN-1:0]     bid,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int BYTES    = DATA_LEN / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam int CNT_W    = 16;
  localparam logic [ADDR_LEN:0] MEM_END = {1'b0, BASE_ADDR} + (ADDR_LEN+1)'(MEM_WORDS * BYTES);

  logic [DATA_LEN-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < MEM_END);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_LEN-1:0] a);
    logic [ADDR_LEN-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> OFF_BITS);
  endfunction

  // Every channel transfers on the rising edge where valid and ready are both
  // high; a held valid keeps its payload stable until that edge.

  // ---------------- read channel ----------------
  rd_state_e           r_state, r_next;
  logic [7:0]          r_len, r_beat, r_fetch_beat;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [ADDR_LEN-1:0] r_addr, r_nxt_addr, r_fetch_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_illegal, r_fetch;

  axi_burst_addr_gen #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) u_rd_addr (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst),
    .next_addr(r_nxt_addr), .illegal(r_illegal)
  );

  assign rvalid = (r_state == R_DATA);

  always_comb begin
    r_next       = r_state;
    r_fetch      = 1'b0;
    r_fetch_addr = (r_state == R_DATA) ? r_nxt_addr : r_addr;
    r_fetch_beat = (r_state == R_DATA) ? r_beat + 8'd1 : 8'd0;
    case (r_state)
      R_IDLE: if (arvalid && arready) r_next = R_WAIT;
      R_WAIT: if (r_cnt == '0) begin
        r_next  = R_DATA;
        r_fetch = 1'b1;
      end
      R_DATA: if (rready) begin
        if (r_beat == r_len) r_next = R_IDLE;
        else                 r_fetch = 1'b1;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rid     <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_addr  <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      if (r_state == R_IDLE && arvalid && arready) begin
        rid     <= arid;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_addr  <= araddr;
        r_beat  <= '0;
        r_cnt   <= CNT_W'(RD_LAT - 1);
      end else if (r_state == R_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // The beat after a handshake is registered at that same edge, so beats are back-to-back.
      if (r_fetch) begin
        r_addr <= r_fetch_addr;
        r_beat <= r_fetch_beat;
        rlast  <= (r_fetch_beat == r_len);
        rresp  <= resp_merge(in_range(r_fetch_addr) ? RESP_OKAY : RESP_DECERR,
                             r_illegal ? RESP_SLVERR : RESP_OKAY);
        rdata  <= in_range(r_fetch_addr) ? mem[word_idx(r_fetch_addr)] : '0;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_e           w_state, w_next;
  logic [7:0]          w_len, w_beat;
  logic [2:0]          w_size;
  logic [1:0]          w_burst, w_err, w_beat_resp;
  logic [ADDR_LEN-1:0] w_addr, w_nxt_addr;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_illegal, w_hs, w_last_beat;

  axi_burst_addr_gen #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) u_wr_addr (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
    .next_addr(w_nxt_addr), .illegal(w_illegal)
  );

  assign wready = (w_state == W_DATA);
  assign bvalid = (w_state == W_RESP);

  always_comb begin
    w_next      = w_state;
    w_hs        = wready && wvalid;
    w_last_beat = (w_beat == w_len);
    // Burst length comes from awlen; wlast only gets checked against it.
    w_beat_resp = resp_merge(in_range(w_addr) ? RESP_OKAY : RESP_DECERR,
                             (w_illegal || (wlast != w_last_beat)) ? RESP_SLVERR : RESP_OKAY);
    case (w_state)
      W_IDLE: if (awvalid && awready) w_next = (WR_LAT == 0) ? W_DATA : W_WAIT;
      W_WAIT: if (w_cnt == '0) w_next = W_DATA;
      W_DATA: if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_addr  <= '0;
      w_beat  <= '0;
      w_cnt   <= '0;
      w_err   <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      awready <= (w_next == W_IDLE);
      if (w_state == W_IDLE && awvalid && awready) begin
        bid     <= awid;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_addr  <= awaddr;
        w_beat  <= '0;
        w_err   <= RESP_OKAY;
        w_cnt   <= CNT_W'((WR_LAT > 0) ? WR_LAT - 1 : 0);
      end else if (w_state == W_WAIT && w_cnt != '0) begin
        w_cnt <= w_cnt - 1'b1;
      end
      if (w_hs) begin
        w_err <= resp_merge(w_err, w_beat_resp);
        if (w_last_beat) begin
          bresp <= resp_merge(w_err, w_beat_resp);
        end else begin
          w_beat <= w_beat + 8'd1;
          w_addr <= w_nxt_addr;
        end
      end
    end
  end

  // Array has no reset so contents survive rstn; out-of-range beats are dropped.
  always_ff @(posedge clk) begin
    if (w_hs && in_range(w_addr)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_burst.sv
// Directed bench for axi_sram_burst: bursts, wrap, strobes, error responses,
// latency and mid-burst reset, checked against hand-computed values.
module tb_axi_sram_burst;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [3:0]  arid, awid, rid, bid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_sram_burst dut (
    .clk(clk), .rstn(rstn),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic        wr_last [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_got;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end just after a falling edge.
  task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit hs = 0;
    araddr = addr; arid = id; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (arready) hs = 1;
      @(negedge clk);
    end
    arvalid = 1'b0;
    check("ar_handshake", 64'(hs), 64'd1);
  endtask

  task automatic r_collect(input bit toggle, input int stop);
    bit          stall = 0;
    bit          phase = 1;
    logic [34:0] held = '0;
    rd_got = 0;
    for (int c = 0; c < 100 && rd_got < stop; c++) begin
      rready = toggle ? phase : 1'b1;
      if (stall && rvalid) check("r_hold", 64'({rlast, rresp, rdata}), 64'(held));
      stall = 0;
      if (rvalid && rready) begin
        rd_data[rd_got] = rdata;
        rd_resp[rd_got] = rresp;
        rd_last[rd_got] = rlast;
        rd_id[rd_got]   = rid;
        rd_got++;
      end else if (rvalid) begin
        stall = 1;
        held  = {rlast, rresp, rdata};
      end
      @(negedge clk);
      phase = ~phase;
    end
    rready = 1'b0;
    check("r_beat_count", 64'(rd_got), 64'(stop));
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    ar_send(addr, id, len, size, burst);
    r_collect(toggle, len + 1);
  endtask

  task automatic w_send(input logic [31:0] addr, input logic [3:0] id, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    bit hs = 0;
    awaddr = addr; awid = id; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (awready) hs = 1;
      @(negedge clk);
    end
    awvalid = 1'b0;
    check("aw_handshake", 64'(hs), 64'd1);
    for (int b = 0; b <= len; b++) begin
      wvalid = 1'b1; wdata = wr_data[b]; wstrb = wr_strb[b]; wlast = wr_last[b];
      hs = 0;
      for (int i = 0; i < 20 && !hs; i++) begin
        if (wready) hs = 1;
        @(negedge clk);
      end
      check("w_handshake", 64'(hs), 64'd1);
      if (b < len) check("b_not_early", 64'(bvalid), 64'd0);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    hs = 0;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (bvalid) begin
        hs = 1; b_resp = bresp; b_id = bid;
      end
      @(negedge clk);
    end
    bready = 1'b0;
    check("b_handshake", 64'(hs), 64'd1);
  endtask

  initial begin
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    b_resp = '0; b_id = '0;

    // reset state and release timing
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({arready, awready, rvalid, rlast, wready, bvalid}), 64'd0);
    check("rst_data", 64'({rdata, rresp, rid, bresp, bid}), 64'd0);
    rstn = 1'b1;
    #1 check("arready_before_edge", 64'({arready, awready}), 64'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 64'({arready, awready}), 64'b11);
    @(negedge clk);

    // single write, single read with latency
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    w_send(32'h8000_0010, 4'd3, 0, 3'd2, 2'b01);
    check("single_bresp", 64'(b_resp), 64'd0);
    check("single_bid", 64'(b_id), 64'd3);
    ar_send(32'h8000_0010, 4'd5, 0, 3'd2, 2'b01);
    check("lat_edge0", 64'(rvalid), 64'd0);
    @(negedge clk);
    check("lat_edge1", 64'(rvalid), 64'd0);
    @(negedge clk);
    check("lat_edge2", 64'(rvalid), 64'd1);
    r_collect(1'b0, 1);
    check("single_rdata", 64'(rd_data[0]), 64'hDEADBEEF);
    check("single_rlast", 64'(rd_last[0]), 64'd1);
    check("single_rid", 64'(rd_id[0]), 64'd5);
    check("single_rresp", 64'(rd_resp[0]), 64'd0);

    // INCR burst with stalled reads
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; wr_data[2] = 32'h33; wr_data[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      wr_strb[i] = 4'hF; wr_last[i] = (i == 3);
    end
    w_send(32'h8000_0100, 4'd6, 3, 3'd2, 2'b01);
    check("incr_bresp", 64'(b_resp), 64'd0);
    read_burst(32'h8000_0100, 4'd7, 3, 3'd2, 2'b01, 1'b1);
    check("incr_d0", 64'(rd_data[0]), 64'h11);
    check("incr_d1", 64'(rd_data[1]), 64'h22);
    check("incr_d2", 64'(rd_data[2]), 64'h33);
    check("incr_d3", 64'(rd_data[3]), 64'h44);
    check("incr_last", 64'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 64'b0001);
    check("incr_rid", 64'(rd_id[3]), 64'd7);

    // WRAP: 0x108, 0x10C, 0x100, 0x104
    read_burst(32'h8000_0108, 4'd2, 3, 3'd2, 2'b10, 1'b0);
    check("wrap_d0", 64'(rd_data[0]), 64'h33);
    check("wrap_d1", 64'(rd_data[1]), 64'h44);
    check("wrap_d2", 64'(rd_data[2]), 64'h11);
    check("wrap_d3", 64'(rd_data[3]), 64'h22);
    check("wrap_resp", 64'({rd_resp[0], rd_resp[3]}), 64'd0);

    // byte strobes over a zeroed word
    wr_data[0] = 32'h0; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    w_send(32'h8000_0000, 4'd1, 0, 3'd2, 2'b01);
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'h5;
    w_send(32'h8000_0000, 4'd1, 0, 3'd2, 2'b01);
    read_burst(32'h8000_0000, 4'd1, 0, 3'd2, 2'b01, 1'b0);
    check("strobe_rdata", 64'(rd_data[0]), 64'h00BB00DD);

    // decode error on read
    read_burst(32'h7FFF_FFF0, 4'd9, 0, 3'd2, 2'b01, 1'b0);
    check("decerr_rresp", 64'(rd_resp[0]), 64'd3);
    check("decerr_rdata", 64'(rd_data[0]), 64'd0);

    // reserved burst type
    read_burst(32'h8000_0100, 4'd4, 1, 3'd2, 2'b11, 1'b0);
    check("rsvd_resp", 64'({rd_resp[0], rd_resp[1]}), 64'b1010);
    check("rsvd_last", 64'({rd_last[0], rd_last[1]}), 64'b01);

    // wlast on the wrong beat: both beats still taken
    wr_data[0] = 32'h5; wr_data[1] = 32'h6;
    wr_strb[0] = 4'hF;  wr_strb[1] = 4'hF;
    wr_last[0] = 1'b1;  wr_last[1] = 1'b0;
    w_send(32'h8000_0200, 4'd8, 1, 3'd2, 2'b01);
    check("wlast_bresp", 64'(b_resp), 64'd2);
    check("wlast_bid", 64'(b_id), 64'd8);

    // decode error on write
    wr_data[0] = 32'h77; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    w_send(32'h7FFF_FFF0, 4'd2, 0, 3'd2, 2'b01);
    check("decerr_bresp", 64'(b_resp), 64'd3);

    // reset after beat 1 of a 4-beat read
    ar_send(32'h8000_0100, 4'd3, 3, 3'd2, 2'b01);
    r_collect(1'b0, 2);
    check("mid_d0", 64'(rd_data[0]), 64'h11);
    check("mid_d1", 64'(rd_data[1]), 64'h22);
    rstn = 1'b0;
    #1 check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_arready", 64'(arready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1 check("mid_rel_arready_pre", 64'(arready), 64'd0);
    @(posedge clk);
    #1 check("mid_rel_arready_post", 64'(arready), 64'd1);
    @(negedge clk);
    read_burst(32'h8000_0010, 4'd5, 0, 3'd2, 2'b01, 1'b0);
    check("retain_0010", 64'(rd_data[0]), 64'hDEADBEEF);
    read_burst(32'h8000_0104, 4'd5, 0, 3'd2, 2'b01, 1'b0);
    check("retain_0104", 64'(rd_data[0]), 64'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
